// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the boot source and the program loader.
interface imem_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;

   modport master (output byte_valid, output byte_data, input byte_ready);
   modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed byte stream into instruction words,
// writes them to instruction memory and holds the CPU in reset until the image is complete.
//
// state  | meaning
// IDLE   | after reset, CPU held, waiting for start
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte, header validated here
// DATA   | collecting the bytes of the current word
// WRITE  | one-cycle instruction memory write of the assembled word
// DONE   | image loaded, CPU released
// ERR    | header rejected, CPU held
module imem_loader #(
   parameter int INSTR_WIDTH = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int MAX_WORDS   = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   imem_loader_if.slave           bs,
   output logic                   imem_we,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   output logic [INSTR_WIDTH-1:0] imem_wdata,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);
   localparam int BPW = INSTR_WIDTH / 8;
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);
   localparam logic [15:0]    MAX_N     = 16'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   state_t                 state, nxt;
   logic [7:0]             len_hi;
   logic [15:0]            len_q;
   logic [15:0]            word_idx;
   logic [BIW-1:0]         byte_idx;
   logic [INSTR_WIDTH-1:0] asm_q;
   logic [INSTR_WIDTH-1:0] asm_nxt;
   logic [15:0]            len_n;
   logic                   len_bad;
   logic                   last_byte;
   logic                   byte_ready;
   logic                   accept;

   assign bs.byte_ready = byte_ready;
   assign accept        = bs.byte_valid && byte_ready;
   assign len_n         = {len_hi, bs.byte_data};
   assign len_bad       = (len_n == 16'd0) || (len_n > MAX_N);
   assign last_byte     = (byte_idx == LAST_BYTE);
   // New byte enters at the LSB, so the first byte received ends up most significant.
   assign asm_nxt       = (asm_q << 8) | INSTR_WIDTH'(bs.byte_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   if (start) nxt = LEN_HI;
         LEN_HI: if (accept) nxt = LEN_LO;
         LEN_LO: if (accept) nxt = len_bad ? ERR : DATA;
         DATA:   if (accept && last_byte) nxt = WRITE;
         WRITE:  nxt = ((word_idx + 16'd1) == len_q) ? DONE : DATA;
         DONE:   if (start) nxt = LEN_HI;
         ERR:    if (start) nxt = LEN_HI;
         default: nxt = IDLE;
      endcase
   end

   // Outputs decode the state register only, so byte_ready never follows byte_valid.
   always_comb begin
      byte_ready = 1'b0;
      imem_we    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         LEN_HI, LEN_LO, DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         WRITE: begin
            imem_we = 1'b1;
            busy    = 1'b1;
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         ERR:     error = 1'b1;
         default: ;
      endcase
   end

   // Write address/data are captured with the final byte and then held between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_hi     <= '0;
         len_q      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         asm_q      <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         case (state)
            LEN_HI: if (accept) len_hi <= bs.byte_data;
            LEN_LO: begin
               if (accept) begin
                  len_q    <= len_n;
                  word_idx <= '0;
                  byte_idx <= '0;
               end
            end
            DATA: begin
               if (accept) begin
                  asm_q <= asm_nxt;
                  if (last_byte) begin
                     byte_idx   <= '0;
                     imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                     imem_wdata <= asm_nxt;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            WRITE: begin
               word_idx <= word_idx + 16'd1;
               byte_idx <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed header/stream scenarios plus randomized images.
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_hold, busy, done, error;

   int checks = 0;
   int failures = 0;
   int we_count = 0;
   int busy_low = 0;
   bit watch_busy = 1'b0;

   logic [15:0] tb_mem  [256];
   logic [15:0] exp_mem [256];
   logic [15:0] words_q [$];

   imem_loader_if bs();

   imem_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bs         (bs),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Instruction memory model plus write/busy observers.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         we_count++;
         tb_mem[imem_addr] = imem_wdata;
      end
      if (watch_busy && busy !== 1'b1) busy_low++;
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bs.byte_valid = 1'b1;
      bs.byte_data  = b;
      while (bs.byte_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bs.byte_ready !== 1'b1) begin
         failures++;
         $display("FAIL byte_accept_timeout byte=%h ready=%b", b, bs.byte_ready);
      end
      @(negedge clk);
      bs.byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full load of words_q with header n_hdr; expectations come from the header rule
   // (1..256 words accepted) and the word list itself.
   task automatic load(input logic [15:0] n_hdr, input bit toggle, input bit mid_start);
      int n = int'(n_hdr);
      bit bad = (n == 0) || (n > 256);
      int base;
      logic [15:0] w;
      pulse_start();
      checks++;
      if ({busy, done, error, cpu_hold} !== 4'b1001) begin
         failures++;
         $display("FAIL start_entry busy/done/error/hold=%b expected 1001", {busy, done, error, cpu_hold});
      end
      busy_low = 0;
      watch_busy = 1'b1;
      base = we_count;
      send_byte(n_hdr[15:8]);
      if (toggle) @(negedge clk);
      send_byte(n_hdr[7:0]);
      if (bad) begin
         watch_busy = 1'b0;
         checks++;
         if ({error, cpu_hold, busy, done, bs.byte_ready} !== 5'b11000) begin
            failures++;
            $display("FAIL header_reject err/hold/busy/done/ready=%b expected 11000 hdr=%h",
                     {error, cpu_hold, busy, done, bs.byte_ready}, n_hdr);
         end
         repeat (3) @(negedge clk);
         checks++;
         if (we_count !== base || error !== 1'b1) begin
            failures++;
            $display("FAIL header_reject_nowrite writes=%0d expected 0 error=%b", we_count - base, error);
         end
         return;
      end
      if (toggle) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         w = words_q[i];
         send_byte(w[15:8]);
         if (toggle) @(negedge clk);
         send_byte(w[7:0]);
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_wdata !== w || cpu_hold !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL word_write idx=%0d we=%b addr=%h data=%h hold=%b done=%b expected we=1 addr=%h data=%h hold=1 done=0",
                     i, imem_we, imem_addr, imem_wdata, cpu_hold, done, 8'(i), w);
         end
         exp_mem[i] = w;
         if (i < n - 1) begin
            if (mid_start && i == 0) pulse_start();
            else if (toggle) @(negedge clk);
         end
      end
      watch_busy = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, cpu_hold, busy, imem_we, error} !== 5'b10000) begin
         failures++;
         $display("FAIL load_done done/hold/busy/we/err=%b expected 10000", {done, cpu_hold, busy, imem_we, error});
      end
      @(negedge clk);
      checks++;
      if (we_count - base !== n || busy_low !== 0) begin
         failures++;
         $display("FAIL write_count writes=%0d expected %0d busy_low_cycles=%0d", we_count - base, n, busy_low);
      end
      begin
         int bad_words = 0;
         for (int i = 0; i < n; i++) if (tb_mem[i] !== exp_mem[i]) bad_words++;
         checks++;
         if (bad_words != 0) begin
            failures++;
            $display("FAIL mem_contents bad_words=%0d expected 0", bad_words);
         end
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bs.byte_ready, imem_we, cpu_hold, busy, done, error} !== 6'b001000 ||
          imem_addr !== 8'h00 || imem_wdata !== 16'h0000) begin
         failures++;
         $display("FAIL reset_values ready/we/hold/busy/done/err=%b addr=%h data=%h expected 001000 00 0000",
                  {bs.byte_ready, imem_we, cpu_hold, busy, done, error}, imem_addr, imem_wdata);
      end
      reset = 1'b1;
      bs.byte_valid = 1'b1;
      bs.byte_data  = 8'h5A;
      repeat (20) begin
         @(negedge clk);
         if ({bs.byte_ready, imem_we, cpu_hold, busy, done, error} !== 6'b001000) bad++;
      end
      bs.byte_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle_hold bad_cycles=%0d expected 0", bad);
      end
   endtask

   task automatic test_stream();
      words_q = '{16'h1234, 16'hABCD, 16'h002A};
      load(16'd3, 1'b0, 1'b0);
   endtask

   task automatic test_toggle();
      words_q = '{16'h1234, 16'hABCD, 16'h002A};
      load(16'd3, 1'b1, 1'b0);
   endtask

   task automatic test_header_error();
      load(16'h0000, 1'b0, 1'b0);
      load(16'h0101, 1'b0, 1'b0);
      words_q = '{16'hBEEF};
      load(16'd1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midload();
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'hAB);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({bs.byte_ready, imem_we, cpu_hold, busy, done, error} !== 6'b001000 ||
          imem_addr !== 8'h00 || imem_wdata !== 16'h0000) begin
         failures++;
         $display("FAIL async_reset ready/we/hold/busy/done/err=%b addr=%h data=%h expected 001000 00 0000",
                  {bs.byte_ready, imem_we, cpu_hold, busy, done, error}, imem_addr, imem_wdata);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      words_q = '{16'h55AA};
      load(16'd1, 1'b0, 1'b0);
   endtask

   task automatic test_restart();
      words_q = '{16'h1122};
      load(16'd1, 1'b0, 1'b0);
      words_q = '{16'h0F0F, 16'hF0F0, 16'h1357};
      load(16'd3, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         int n = $urandom_range(1, 12);
         words_q.delete();
         for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
         load(16'(n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      load(16'($urandom_range(257, 65535)), 1'b1, 1'b0);
      words_q.delete();
      for (int i = 0; i < 5; i++) words_q.push_back(16'($urandom));
      load(16'd5, 1'b1, 1'b0);
   endtask

   initial begin
      bs.byte_valid = 1'b0;
      bs.byte_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_stream();
      test_toggle();
      test_header_error();
      test_reset_midload();
      test_restart();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle `cpu`.
- Accepts a byte stream over a valid/ready handshake and assembles it into instruction words.
- Writes each word into instruction memory and holds the CPU in reset until the whole image is loaded.
- On successful completion it releases `cpu_hold`, which drives the CPU's reset input, so the CPU starts executing from address 0.

Parameters:
- INSTR_WIDTH, 16, instruction word width in bits; must be a multiple of 8. BPW = INSTR_WIDTH/8 bytes per word.
- ADDR_WIDTH, 8, instruction memory address width.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE, DONE and ERR.
- byte_valid  input  1  upstream byte present.
- byte_data  input  8  upstream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_WIDTH  word address to write.
- imem_wdata  output  INSTR_WIDTH  word to write.
- cpu_hold  output  1  high means the CPU is held in reset.
- busy  output  1  high in LEN_HI, LEN_LO, DATA and WRITE.
- done  output  1  load completed successfully.
- error  output  1  header was rejected.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, internal counters=0. Instruction memory contents are not touched.
- Byte acceptance: a byte is accepted on a rising edge where byte_valid && byte_ready.
  - byte_ready=1 only in LEN_HI, LEN_LO and DATA.
  - byte_ready is registered and does not depend combinationally on byte_valid.
- Stream format:
  - 2-byte big-endian word count N.
  - Followed by N*BPW data bytes.
  - Each word is sent MSB byte first.
- States:
  - IDLE: cpu_hold=1. start → LEN_HI.
  - LEN_HI: on accept, latch count[15:8] → LEN_LO.
  - LEN_LO: on accept, form N = {hi, byte}.
    - N==0 or N>MAX_WORDS → ERR.
    - Otherwise clear word_idx and byte_idx → DATA.
  - DATA: on accept, shift the byte into the assembly register (new byte enters the LSB) and increment byte_idx. The accept that completes byte BPW-1 → WRITE.
  - WRITE (exactly 1 cycle):
    - imem_we=1, imem_addr=word_idx[ADDR_WIDTH-1:0], imem_wdata=assembled word, byte_ready=0.
    - Next cycle: imem_we=0, word_idx+1, byte_idx=0.
    - → DONE if word_idx+1==N, else → DATA.
  - DONE: done=1, cpu_hold=0; holds until start. start → LEN_HI with done=0, cpu_hold=1 on the same edge.
  - ERR: error=1, cpu_hold=1; holds until start. start → LEN_HI with error=0.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE. It has no effect on an in-progress load.
- Throughput: each word costs BPW accept cycles plus 1 WRITE cycle. Upstream stalls (byte_valid=0) simply hold the current state.
- imem_addr and imem_wdata keep their last written values when imem_we=0.
- The CPU is never released mid-load. cpu_hold falls only on entry to DONE: one cycle after the final WRITE cycle, and never before the final write has been issued.
- Reset mid-load: returns immediately to IDLE with cpu_hold=1. Partially written memory is left as-is, and the next load overwrites it.
- Bytes presented while byte_ready=0 are not consumed. Upstream must hold them stable until accepted.

Test Plan:
- Reset with reset=0 for 2 cycles → all outputs at reset values (cpu_hold=1, byte_ready=0, imem_we=0); release reset, no start → state stays IDLE for 20 cycles.
- start, stream 00 03 | 12 34 | AB CD | 00 2A with byte_valid held high → three imem_we pulses: addr0=0x1234, addr1=0xABCD, addr2=0x002A, each one cycle after its second byte is accepted; done=1 and cpu_hold=0 one cycle after the third write.
- Same 3-word load with byte_valid toggled 1/0 every cycle → identical writes and values; no byte dropped or duplicated; busy=1 throughout.
- Header 00 00 → error=1, cpu_hold=1, no imem_we. Then start with header 01 01 (257 > 256) → error=1 again. Then start with a valid 1-word load 00 01 BE EF → error=0, addr0=0xBEEF, done=1.
- Drive reset=0 during the second word of a 3-word load → outputs go to reset values immediately. Reload 00 01 55 AA → addr0=0x55AA, done=1.
- In DONE, pulse start and send 00 01 11 22 → done drops and cpu_hold rises on the start edge; one write addr0=0x1122, then done=1. A start pulse asserted mid-load has no effect.
